// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, error pattern and responder FSM states for the 32-bit memory bus
package mem_bus_pkg;
  localparam int MEM_WORD_W = 32;
  localparam logic [MEM_WORD_W-1:0] MEM_ERR_PATTERN = 32'hDEADBEEF;
  localparam int MEM_WCNT_W = 4;
  typedef enum logic {IDLE, WAIT} fsm_t;
endpackage

// File: rtl/mem_array_32.sv
// mem_array_32: single-port word RAM, synchronous write, registered write-first read
module mem_array_32
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);
  logic [MEM_WORD_W-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata <= wdata;
    end else rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder_32.sv
// mem_responder_32: RAM target for the CPU memory bus with wait states and range/protect errors
// Optional write protection of the low WP_LIMIT bytes is enabled by defining MEM_WRITE_PROTECT_EN.
module mem_responder_32
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] WP_LIMIT    = 32'h00000100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_ready,
  output logic        bus_err
);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif
  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;
  fsm_t                  fsm, fsm_nx;
  logic                  valid_q, we_q, err_q, match, oor, prot, ram_we, unused;
  logic [29:0]           addr_q;
  logic [MEM_WCNT_W-1:0] wcnt;
  logic [31:0]           off, ram_q, rdata;
  assign unused = mem_read;
  always_comb begin
    off   = addr_bus - BASE_ADDR;
    oor   = {1'b0, off} >= SPAN;
    prot  = WP_ON && mem_write && off < WP_LIMIT;
    match = valid_q && addr_q == addr_bus[31:2] && we_q == mem_write;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else fsm <= fsm_nx;
  end
  always_comb begin
    fsm_nx = !match ? (WAIT_STATES > 0 ? WAIT : IDLE)
           : (fsm == WAIT && wcnt == 1) ? IDLE : fsm;
  end
  always_comb begin
    mem_ready = fsm == IDLE && match;
    bus_err   = mem_ready && err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wcnt    <= '0;
    end else if (!match) begin
      valid_q <= 1'b1;
      addr_q  <= addr_bus[31:2];
      we_q    <= mem_write;
      err_q   <= oor || prot;
      wcnt    <= MEM_WCNT_W'(WAIT_STATES);
    end else if (fsm == WAIT) wcnt <= wcnt - 1'b1;
  end
  // The RAM read register tracks addr_bus every cycle, so it holds the captured word once ready rises
  assign ram_we = mem_ready && mem_write && !err_q;
  mem_array_32 #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (off[ADDR_WIDTH+1:2]),
    .wdata(data_bus),
    .rdata(ram_q)
  );
  assign rdata    = !valid_q ? '0 : err_q ? MEM_ERR_PATTERN : ram_q;
  assign data_bus = mem_write ? 'z : rdata;
endmodule
